// File: rtl/dual_fetch_queue.sv
// Front-end fetch queue: pulls two 16-bit words per cycle into a circular
// buffer and presents the two oldest entries as an issue pair.
module dual_fetch_queue #(
  parameter int              PC_W     = 8,
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic [PC_W-1:0] imem_addr,
  input  logic [15:0]     imem_rdata0,
  input  logic [15:0]     imem_rdata1,
  input  logic            issue_ready,
  input  logic            issingleinstr,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  output logic [15:0]     instr1_out,
  output logic [15:0]     instr2_out,
  output logic            valid1,
  output logic            valid2,
  output logic [PC_W-1:0] head_pc
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [15:0]     instr_mem [DEPTH];
  logic [PC_W-1:0] pc_mem    [DEPTH];

  logic [PC_W-1:0]  fetch_pc;
  logic [PTR_W-1:0] head, tail;
  logic [PTR_W-1:0] head_p1, tail_p1;
  logic [CNT_W-1:0] count;
  logic             fetch_en;
  logic [1:0]       retire_n;

  assign head_p1   = head + PTR_W'(1);
  assign tail_p1   = tail + PTR_W'(1);
  assign imem_addr = fetch_pc;
  assign valid1    = (count != '0);
  assign valid2    = (count >= CNT_W'(2));

  // Fetch is gated on the current occupancy only, so two free slots are
  // guaranteed at tail and tail+1 regardless of this cycle's retire.
  assign fetch_en  = (count <= CNT_W'(DEPTH - 2)) && !redirect;

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    retire_n = 2'd0;
    if (issue_ready && valid1 && !redirect)
      retire_n = (issingleinstr || !valid2) ? 2'd1 : 2'd2;
  end

  assign instr1_out = valid1 ? instr_mem[head]    : 16'h0000;
  assign instr2_out = valid2 ? instr_mem[head_p1] : 16'h0000;
  assign head_pc    = valid1 ? pc_mem[head]       : '0;

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      if (fetch_en) begin
        tail     <= tail + PTR_W'(2);
        fetch_pc <= fetch_pc + PC_W'(2);
      end
      head  <= head + PTR_W'(retire_n);
      count <= count - CNT_W'(retire_n) + (fetch_en ? CNT_W'(2) : CNT_W'(0));
    end
  end

  // NOTE: entry storage is deliberately not reset; outputs are masked by the
  // valid flags, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (fetch_en && !rst) begin
      instr_mem[tail]    <= imem_rdata0;
      pc_mem[tail]       <= fetch_pc;
      instr_mem[tail_p1] <= imem_rdata1;
      pc_mem[tail_p1]    <= fetch_pc + PC_W'(1);
    end
  end

endmodule

// File: tb/tb_dual_fetch_queue.sv
// Bench for dual_fetch_queue: directed scenarios plus random traffic, all
// compared against a queue-based reference model.
module tb_dual_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_ready;
  logic        issingleinstr;
  logic        redirect;
  logic [7:0]  redirect_pc;

  logic [7:0]  imem_addr, addr_p1;
  logic [15:0] imem_rdata0, imem_rdata1;
  logic [15:0] instr1_out, instr2_out;
  logic        valid1, valid2;
  logic [7:0]  head_pc;

  logic [7:0]  fe_addr, fe_addr_p1;
  logic [15:0] fe_rdata0, fe_rdata1;
  logic [15:0] fe_instr1, fe_instr2;
  logic        fe_valid1, fe_valid2;
  logic [7:0]  fe_head_pc;

  logic [15:0] mem [256];

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] instr;
    logic [7:0]  pc;
  } ent_t;

  ent_t       q[$];
  logic [7:0] m_fpc;
  bit         model_on = 1'b0;

  always #5 clk = ~clk;

  assign addr_p1     = imem_addr + 8'd1;
  assign imem_rdata0 = mem[imem_addr];
  assign imem_rdata1 = mem[addr_p1];
  assign fe_addr_p1  = fe_addr + 8'd1;
  assign fe_rdata0   = mem[fe_addr];
  assign fe_rdata1   = mem[fe_addr_p1];

  dual_fetch_queue #(.PC_W(8), .DEPTH(4), .RESET_PC(8'h00)) u_dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr),
    .imem_rdata0(imem_rdata0), .imem_rdata1(imem_rdata1),
    .issue_ready(issue_ready), .issingleinstr(issingleinstr),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .instr1_out(instr1_out), .instr2_out(instr2_out),
    .valid1(valid1), .valid2(valid2), .head_pc(head_pc)
  );

  dual_fetch_queue #(.PC_W(8), .DEPTH(4), .RESET_PC(8'hFE)) u_dut_fe (
    .clk(clk), .rst(rst), .imem_addr(fe_addr),
    .imem_rdata0(fe_rdata0), .imem_rdata1(fe_rdata1),
    .issue_ready(issue_ready), .issingleinstr(issingleinstr),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .instr1_out(fe_instr1), .instr2_out(fe_instr2),
    .valid1(fe_valid1), .valid2(fe_valid2), .head_pc(fe_head_pc)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_compare();
    logic [15:0] e_i1, e_i2;
    logic [7:0]  e_pc;
    e_i1 = (q.size() >= 1) ? q[0].instr : 16'h0000;
    e_i2 = (q.size() >= 2) ? q[1].instr : 16'h0000;
    e_pc = (q.size() >= 1) ? q[0].pc    : 8'h00;
    check("m_valid1", 32'(valid1), 32'(q.size() >= 1));
    check("m_valid2", 32'(valid2), 32'(q.size() >= 2));
    check("m_instr1", 32'(instr1_out), 32'(e_i1));
    check("m_instr2", 32'(instr2_out), 32'(e_i2));
    check("m_head_pc", 32'(head_pc), 32'(e_pc));
    check("m_imem_addr", 32'(imem_addr), 32'(m_fpc));
  endtask

  // Queue-level behaviour: pop what is retired, append what is fetched.
  task automatic model_update();
    int         n;
    bit         do_fetch;
    logic [7:0] p1;
    if (rst) begin
      q.delete();
      m_fpc    = 8'h00;
      model_on = 1'b1;
    end else if (!model_on) begin
      // nothing known before the first reset
    end else if (redirect) begin
      q.delete();
      m_fpc = redirect_pc;
    end else begin
      do_fetch = (q.size() <= 2);
      if (!issue_ready || q.size() == 0) n = 0;
      else if (issingleinstr || q.size() < 2) n = 1;
      else n = 2;
      repeat (n) void'(q.pop_front());
      if (do_fetch) begin
        p1 = m_fpc + 8'd1;
        q.push_back('{instr: mem[m_fpc], pc: m_fpc});
        q.push_back('{instr: mem[p1], pc: p1});
        m_fpc = m_fpc + 8'd2;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (model_on) model_compare();
    model_update();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
    rst = 1'b1; issue_ready = 1'b1; issingleinstr = 1'b0;
    redirect = 1'b0; redirect_pc = 8'h00;

    // Reset then streaming dual retire
    tick();
    check("rst_valid1", 32'(valid1), 32'd0);
    check("rst_instr1", 32'(instr1_out), 32'd0);
    check("rst_head_pc", 32'(head_pc), 32'd0);
    rst = 1'b0;
    tick();
    check("c1_instr1", 32'(instr1_out), 32'h1000);
    check("c1_instr2", 32'(instr2_out), 32'h1001);
    check("c1_head_pc", 32'(head_pc), 32'h00);
    tick();
    check("c2_instr1", 32'(instr1_out), 32'h1002);
    check("c2_instr2", 32'(instr2_out), 32'h1003);
    check("c2_head_pc", 32'(head_pc), 32'h02);
    repeat (4) tick();

    // Single retire every cycle
    rst = 1'b1; issingleinstr = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("single_head_pc", 32'(head_pc), 32'(k));
      check("single_instr1", 32'(instr1_out), 32'(16'h1000 + 16'(k)));
      check("single_instr2", 32'(instr2_out), 32'(16'h1001 + 16'(k)));
    end

    // Hold with issue_ready low until full, then release
    rst = 1'b1; issue_ready = 1'b0; issingleinstr = 1'b0;
    tick();
    rst = 1'b0;
    repeat (5) tick();
    check("hold_instr1", 32'(instr1_out), 32'h1000);
    check("hold_instr2", 32'(instr2_out), 32'h1001);
    check("hold_addr", 32'(imem_addr), 32'h04);
    issue_ready = 1'b1;
    tick();
    check("rel1_instr1", 32'(instr1_out), 32'h1002);
    check("rel1_instr2", 32'(instr2_out), 32'h1003);
    tick();
    check("rel2_instr1", 32'(instr1_out), 32'h1004);
    check("rel2_instr2", 32'(instr2_out), 32'h1005);

    // Redirect with three entries queued
    rst = 1'b1; issingleinstr = 1'b1;
    tick();
    rst = 1'b0;
    repeat (2) tick();
    redirect = 1'b1; redirect_pc = 8'h40;
    tick();
    check("redir_valid1", 32'(valid1), 32'd0);
    check("redir_valid2", 32'(valid2), 32'd0);
    check("redir_addr", 32'(imem_addr), 32'h40);
    redirect = 1'b0; issingleinstr = 1'b0;
    tick();
    check("redir_instr1", 32'(instr1_out), 32'h1040);
    check("redir_instr2", 32'(instr2_out), 32'h1041);
    check("redir_head_pc", 32'(head_pc), 32'h40);

    // Reset wins over a simultaneous redirect
    repeat (3) tick();
    rst = 1'b1; redirect = 1'b1; redirect_pc = 8'h40;
    tick();
    check("rr_valid1", 32'(valid1), 32'd0);
    check("rr_instr1", 32'(instr1_out), 32'd0);
    check("rr_head_pc", 32'(head_pc), 32'd0);
    check("rr_addr", 32'(imem_addr), 32'h00);
    rst = 1'b0; redirect = 1'b0;
    tick();
    check("rr_first_instr1", 32'(instr1_out), 32'h1000);
    check("rr_first_head_pc", 32'(head_pc), 32'h00);

    // PC wrap-around on the RESET_PC=FE instance
    mem[8'hFE] = 16'hAAAA; mem[8'hFF] = 16'hBBBB;
    mem[8'h00] = 16'hCCCC; mem[8'h01] = 16'hDDDD;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("wrap1_instr1", 32'(fe_instr1), 32'hAAAA);
    check("wrap1_instr2", 32'(fe_instr2), 32'hBBBB);
    check("wrap1_head_pc", 32'(fe_head_pc), 32'hFE);
    tick();
    check("wrap2_instr1", 32'(fe_instr1), 32'hCCCC);
    check("wrap2_instr2", 32'(fe_instr2), 32'hDDDD);
    check("wrap2_head_pc", 32'(fe_head_pc), 32'h00);

    // Random traffic against the model
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    for (int c = 0; c < 500; c++) begin
      rst           = ($urandom_range(0, 59) == 0);
      redirect      = ($urandom_range(0, 11) == 0);
      redirect_pc   = 8'($urandom);
      issue_ready   = ($urandom_range(0, 3) != 0);
      issingleinstr = ($urandom_range(0, 2) == 0);
      tick();
    end
    rst = 1'b0; redirect = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
